// File: rtl/pzbcm_sram_fifo_controller_pkg.sv
// Width helpers shared by the SRAM FIFO controller, its interface and its pointer sub-module.
package pzbcm_sram_fifo_pkg;

    function automatic int unsigned calc_pointer_width(int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Occupancy must be able to hold the value WORDS itself, hence words + 1.
    function automatic int unsigned calc_count_width(int unsigned words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/pzbcm_sram_fifo_controller_if.sv
// Push/SRAM/pop signal bundle of the SRAM FIFO controller.
// Status signals exist only when PZBCM_SRAM_FIFO_CONTROLLER_STATUS_EN is defined.
interface pzbcm_sram_fifo_controller_if
    import pzbcm_sram_fifo_pkg::*;
#(
    parameter int unsigned WORDS      = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned PW = calc_pointer_width(WORDS);

    logic                  i_push_valid;
    logic                  o_push_ready;
    logic [DATA_WIDTH-1:0] i_push_data;
    logic                  o_write_valid;
    logic                  i_write_ready;
    logic [PW-1:0]         o_write_pointer;
    logic [DATA_WIDTH-1:0] o_write_data;
    logic                  o_read_valid;
    logic                  i_read_ready;
    logic [PW-1:0]         o_read_pointer;
    logic                  i_pop;
    logic                  o_empty;
    logic                  o_full;

`ifdef PZBCM_SRAM_FIFO_CONTROLLER_STATUS_EN
    localparam int unsigned CW = calc_count_width(WORDS);

    logic [CW-1:0]         o_word_count;
    logic                  o_almost_full;

    modport master (
        input  i_push_valid, i_push_data, i_write_ready, i_read_ready, i_pop,
        output o_push_ready, o_write_valid, o_write_pointer, o_write_data,
        output o_read_valid, o_read_pointer, o_empty, o_full,
        output o_word_count, o_almost_full
    );

    modport slave (
        output i_push_valid, i_push_data, i_write_ready, i_read_ready, i_pop,
        input  o_push_ready, o_write_valid, o_write_pointer, o_write_data,
        input  o_read_valid, o_read_pointer, o_empty, o_full,
        input  o_word_count, o_almost_full
    );
`else
    modport master (
        input  i_push_valid, i_push_data, i_write_ready, i_read_ready, i_pop,
        output o_push_ready, o_write_valid, o_write_pointer, o_write_data,
        output o_read_valid, o_read_pointer, o_empty, o_full
    );

    modport slave (
        output i_push_valid, i_push_data, i_write_ready, i_read_ready, i_pop,
        input  o_push_ready, o_write_valid, o_write_pointer, o_write_data,
        input  o_read_valid, o_read_pointer, o_empty, o_full
    );
`endif

endinterface

// File: rtl/pzbcm_sram_fifo_controller_pointer.sv
// Wrap-around SRAM address pointer (WORDS-1 -> 0) with increment, synchronous clear
// and asynchronous active-high reset.
module pzbcm_sram_fifo_pointer
    import pzbcm_sram_fifo_pkg::*;
#(
    parameter  int unsigned WORDS = 8,
    localparam int unsigned PW    = calc_pointer_width(WORDS)
)(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_increment,
    output logic [PW-1:0] o_pointer
);
    logic [PW-1:0] pointer_q;
    logic [PW-1:0] pointer_d;

    // WORDS need not be a power of two, so the wrap is an explicit compare.
    always_comb begin
        pointer_d = pointer_q;
        if (i_increment) begin
            if (pointer_q == PW'(WORDS - 1)) begin
                pointer_d = '0;
            end else begin
                pointer_d = pointer_q + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pointer_q <= '0;
        end else if (i_clear) begin
            pointer_q <= '0;
        end else begin
            pointer_q <= pointer_d;
        end
    end

    assign o_pointer = pointer_q;

endmodule

// File: rtl/pzbcm_sram_fifo_controller.sv
// Pointer/occupancy controller turning a pzbcm_sram macro into a FIFO.
// Optional status outputs under PZBCM_SRAM_FIFO_CONTROLLER_STATUS_EN.
module pzbcm_sram_fifo_controller
    import pzbcm_sram_fifo_pkg::*;
#(
    parameter int unsigned WORDS                 = 8,
    parameter int unsigned DATA_WIDTH            = 8,
    parameter int unsigned ALMOST_FULL_THRESHOLD = WORDS - 2
)(
    input logic                           i_clk,
    input logic                           i_rst,
    input logic                           i_clear,
    pzbcm_sram_fifo_controller_if.master  fifo_if
);
    localparam int unsigned PW = calc_pointer_width(WORDS);
    localparam int unsigned CW = calc_count_width(WORDS);

    logic [CW-1:0]         occupancy_q;
    logic [CW-1:0]         occupancy_d;
    logic [CW-1:0]         unread_q;
    logic [CW-1:0]         unread_d;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  read;
    logic                  pop;
    logic [PW-1:0]         write_pointer;
    logic [PW-1:0]         read_pointer;
    logic [DATA_WIDTH-1:0] push_data;

    // Full comes from registered occupancy only: a pop never frees a slot in the same cycle.
    assign full  = (occupancy_q == CW'(WORDS));
    assign empty = (occupancy_q == '0);

    assign push_data              = fifo_if.i_push_data;
    assign fifo_if.o_write_data    = push_data;
    assign fifo_if.o_write_valid   = fifo_if.i_push_valid && !full;
    assign fifo_if.o_push_ready    = !full && fifo_if.i_write_ready;
    assign fifo_if.o_write_pointer = write_pointer;
    assign fifo_if.o_read_valid    = (unread_q != '0);
    assign fifo_if.o_read_pointer  = read_pointer;
    assign fifo_if.o_empty         = empty;
    assign fifo_if.o_full          = full;

    assign push = fifo_if.i_push_valid && fifo_if.o_push_ready;
    assign read = fifo_if.o_read_valid && fifo_if.i_read_ready;
    assign pop  = fifo_if.i_pop && !empty;

    pzbcm_sram_fifo_pointer #(
        .WORDS (WORDS)
    ) u_write_pointer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (i_clear),
        .i_increment (push),
        .o_pointer   (write_pointer)
    );

    pzbcm_sram_fifo_pointer #(
        .WORDS (WORDS)
    ) u_read_pointer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (i_clear),
        .i_increment (read),
        .o_pointer   (read_pointer)
    );

    always_comb begin
        occupancy_d = occupancy_q;
        if (push && !pop) begin
            occupancy_d = occupancy_q + CW'(1);
        end else if (!push && pop) begin
            occupancy_d = occupancy_q - CW'(1);
        end
    end

    always_comb begin
        unread_d = unread_q;
        if (push && !read) begin
            unread_d = unread_q + CW'(1);
        end else if (!push && read) begin
            unread_d = unread_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            occupancy_q <= '0;
            unread_q    <= '0;
        end else if (i_clear) begin
            occupancy_q <= '0;
            unread_q    <= '0;
        end else begin
            occupancy_q <= occupancy_d;
            unread_q    <= unread_d;
        end
    end

`ifdef PZBCM_SRAM_FIFO_CONTROLLER_STATUS_EN
    assign fifo_if.o_word_count  = occupancy_q;
    assign fifo_if.o_almost_full = (occupancy_q >= CW'(ALMOST_FULL_THRESHOLD));
`endif

    // A pop with nothing stored means the consumer and this controller disagree.
    assert property (@(posedge i_clk) disable iff (i_rst) !(fifo_if.i_pop && empty));

endmodule

// File: tb/tb_pzbcm_sram_fifo_controller.sv
// Self-checking bench: event-count model of the FIFO plus an SRAM stand-in for data ordering.
module tb_pzbcm_sram_fifo_controller;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    logic clear;

    pzbcm_sram_fifo_controller_if #(.WORDS(W), .DATA_WIDTH(8)) fifo_if ();

    pzbcm_sram_fifo_controller #(
        .WORDS                 (W),
        .DATA_WIDTH            (8),
        .ALMOST_FULL_THRESHOLD (6)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (clear),
        .fifo_if (fifo_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: everything is derived from event counts since the last reset/clear.
    int n_push = 0;
    int n_read = 0;
    int n_pop  = 0;
    logic [7:0] mem [W];
    logic [7:0] expq [$];
    logic [7:0] rdq [$];
    logic [7:0] popped [$];
    bit checking = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Model and SRAM stand-in, advanced on each active edge from pre-edge values.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst || clear) begin
            n_push = 0; n_read = 0; n_pop = 0;
            expq.delete();
            rdq.delete();
        end else begin
            int  occ;
            bit  pa, ra, pp;
            logic [7:0] v;
            occ = n_push - n_pop;
            pa  = fifo_if.i_push_valid && fifo_if.i_write_ready && (occ != W);
            ra  = fifo_if.i_read_ready && (n_push - n_read != 0);
            pp  = fifo_if.i_pop && (occ != 0);
            if (pp) begin
                if (rdq.size() == 0 || expq.size() == 0) begin
                    check("pop_data_available", 0, 1);
                end else begin
                    v = rdq.pop_front();
                    check("pop_data", int'(v), int'(expq.pop_front()));
                    popped.push_back(v);
                end
            end
            if (fifo_if.o_read_valid && fifo_if.i_read_ready)
                rdq.push_back(mem[fifo_if.o_read_pointer]);
            if (fifo_if.o_write_valid && fifo_if.i_write_ready)
                mem[fifo_if.o_write_pointer] = fifo_if.o_write_data;
            if (pa) expq.push_back(fifo_if.i_push_data);
            if (pa) n_push++;
            if (ra) n_read++;
            if (pp) n_pop++;
        end
    end

    // Compare process: every output against the model, mid-cycle.
    initial forever begin
        @(negedge clk);
        if (checking && !rst) begin
            int  occ;
            bit  m_full;
            occ    = n_push - n_pop;
            m_full = (occ == W);
            check("full", int'(fifo_if.o_full), int'(m_full));
            check("empty", int'(fifo_if.o_empty), int'(occ == 0));
            check("read_valid", int'(fifo_if.o_read_valid), int'(n_push - n_read != 0));
            check("write_pointer", int'(fifo_if.o_write_pointer), n_push % W);
            check("read_pointer", int'(fifo_if.o_read_pointer), n_read % W);
            check("push_ready", int'(fifo_if.o_push_ready),
                  int'(!m_full && fifo_if.i_write_ready));
            check("write_valid", int'(fifo_if.o_write_valid),
                  int'(!m_full && fifo_if.i_push_valid));
            check("write_data", int'(fifo_if.o_write_data), int'(fifo_if.i_push_data));
`ifdef PZBCM_SRAM_FIFO_CONTROLLER_STATUS_EN
            check("word_count", int'(fifo_if.o_word_count), occ);
            check("almost_full", int'(fifo_if.o_almost_full), int'(occ >= 6));
`endif
        end
    end

    task automatic step(input logic pv, input logic [7:0] pd, input logic wr, input logic rr,
                        input logic pop_en, input logic clr);
        fifo_if.i_push_valid  = pv;
        fifo_if.i_push_data   = pd;
        fifo_if.i_write_ready = wr;
        fifo_if.i_read_ready  = rr;
        fifo_if.i_pop         = pop_en && (rdq.size() != 0);
        clear                 = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        clear = 0;
        fifo_if.i_push_valid  = 0;
        fifo_if.i_push_data   = 0;
        fifo_if.i_write_ready = 1;
        fifo_if.i_read_ready  = 0;
        fifo_if.i_pop         = 0;

        // Reset state.
        #2;
        check("rst_empty", int'(fifo_if.o_empty), 1);
        check("rst_full", int'(fifo_if.o_full), 0);
        check("rst_read_valid", int'(fifo_if.o_read_valid), 0);
        check("rst_write_pointer", int'(fifo_if.o_write_pointer), 0);
        check("rst_read_pointer", int'(fifo_if.o_read_pointer), 0);
        check("rst_push_ready", int'(fifo_if.o_push_ready), 1);
        check("rst_write_valid_lo", int'(fifo_if.o_write_valid), 0);
        fifo_if.i_push_valid = 1;
        #1 check("rst_write_valid_hi", int'(fifo_if.o_write_valid), 1);
        fifo_if.i_push_valid  = 0;
        fifo_if.i_write_ready = 0;
        #1 check("rst_push_ready_lo", int'(fifo_if.o_push_ready), 0);
        fifo_if.i_write_ready = 1;
        @(posedge clk);
        #1 rst = 0;
        checking = 1;

        // Fill and drain.
        for (int i = 0; i < 8; i++) step(1, 8'(i), 1, 0, 0, 0);
        check("fill_full", int'(fifo_if.o_full), 1);
        step(1, 8'd99, 1, 0, 0, 0);
        check("fill_push_rejected_full", int'(fifo_if.o_full), 1);
        repeat (12) step(0, 8'd0, 1, 1, 1, 0);
        check("drain_empty", int'(fifo_if.o_empty), 1);
        check("drain_read_pointer", int'(fifo_if.o_read_pointer), 0);

        // Wrap and order.
        popped.delete();
        for (int i = 0; i < 12; i++) step(1, 8'(i), 1, 1, 1, 0);
        check("wrap_write_pointer", int'(fifo_if.o_write_pointer), 4);
        repeat (4) step(0, 8'd0, 1, 1, 1, 0);
        check("wrap_empty", int'(fifo_if.o_empty), 1);
        check("wrap_pop_count", popped.size(), 12);
        for (int i = 0; i < 12 && i < popped.size(); i++)
            check("wrap_pop_order", int'(popped[i]), i);

        // Full with a coincident pop.
        for (int i = 0; i < 8; i++) step(1, 8'(100 + i), 1, 1, 0, 0);
        check("fwp_full", int'(fifo_if.o_full), 1);
        step(1, 8'd200, 1, 0, 1, 0);
        check("fwp_after_pop_not_full", int'(fifo_if.o_full), 0);
        step(1, 8'd201, 1, 0, 0, 0);
        check("fwp_push_accepted_full", int'(fifo_if.o_full), 1);
        repeat (12) step(0, 8'd0, 1, 1, 1, 0);
        check("fwp_empty", int'(fifo_if.o_empty), 1);

        // Read backpressure with three unread words.
        for (int i = 0; i < 3; i++) step(1, 8'(50 + i), 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'd0, 1, 0, 0, 0);
            check("bp_read_valid_held", int'(fifo_if.o_read_valid), 1);
            check("bp_read_pointer_stable", int'(fifo_if.o_read_pointer), 5);
        end
        repeat (3) step(0, 8'd0, 1, 1, 0, 0);
        check("bp_reads_done", int'(fifo_if.o_read_valid), 0);
        check("bp_read_pointer_after", int'(fifo_if.o_read_pointer), 0);
        repeat (4) step(0, 8'd0, 1, 1, 1, 0);
        check("bp_empty", int'(fifo_if.o_empty), 1);

        // Clear with a coincident push.
        for (int i = 0; i < 5; i++) step(1, 8'(60 + i), 1, 0, 0, 0);
        check("clr_write_pointer_before", int'(fifo_if.o_write_pointer), 5);
        step(1, 8'd77, 1, 0, 0, 1);
        check("clr_empty", int'(fifo_if.o_empty), 1);
        check("clr_write_pointer", int'(fifo_if.o_write_pointer), 0);
        check("clr_read_pointer", int'(fifo_if.o_read_pointer), 0);
        check("clr_read_valid", int'(fifo_if.o_read_valid), 0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) step(1, 8'(i), 1, 1, 1, 0);
        fifo_if.i_pop = 0;
        @(posedge clk);
        #3 rst = 1;
        #1;
        check("arst_empty", int'(fifo_if.o_empty), 1);
        check("arst_full", int'(fifo_if.o_full), 0);
        check("arst_write_pointer", int'(fifo_if.o_write_pointer), 0);
        check("arst_read_pointer", int'(fifo_if.o_read_pointer), 0);
        check("arst_read_valid", int'(fifo_if.o_read_valid), 0);
        fifo_if.i_push_valid = 0;
        fifo_if.i_read_ready = 0;
        @(posedge clk);
        #1 rst = 0;

`ifdef PZBCM_SRAM_FIFO_CONTROLLER_STATUS_EN
        check("st_word_count_0", int'(fifo_if.o_word_count), 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(i), 1, 0, 0, 0);
            check("st_word_count", int'(fifo_if.o_word_count), i + 1);
            check("st_almost_full", int'(fifo_if.o_almost_full), int'(i + 1 >= 6));
        end
`endif

        step(0, 8'd0, 1, 0, 0, 0);
        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
